signed_pow2_shift_divide_pipe: RTL and testbench

- Pipelined, width-parametrised right shifter for signed and unsigned data. Shift amount and mode are per transaction.
- Three modes per transaction:
  - arithmetic shift: floor(a / 2^s)
  - signed divide: truncate toward zero, matching `/`
  - logical shift
- Successor to the fixed-S combinational arithmetic shifters. Used by arithmetic datapaths that need divide-by-power-of-2 at full clock rate.
- Valid-only streaming interface with no backpressure, in the style of the other pipelined arithmetic blocks.

---
 rtl/signed_pow2_shift_divide_pipe.sv | 114 +++++++++++
 tb/tb_signed_pow2_shift_divide_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_pow2_shift_divide_pipe.sv
// Pipelined signed/unsigned right shifter: arithmetic shift, divide-by-2^s toward zero,
// or logical shift, selected per transaction; one pre-stage plus one stage per shift bit.
module signed_pow2_shift_divide_pipe #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arg_vld,
    input  logic [N-1:0]  arg,
    input  logic [SW-1:0] arg_shift,
    input  logic [1:0]    arg_mode,
    output logic          res_vld,
    output logic [N-1:0]  res
);

    // Valid-only stream: arg/arg_shift/arg_mode are taken on any rising edge where
    // arg_vld=1; res is meaningful exactly when res_vld=1 and holds otherwise. No backpressure.

    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    logic          w_is_lsr;
    logic          w_is_div;
    logic [N-1:0]  w_bias;
    logic [N-1:0]  w_pre_data;
    logic          w_pre_fill;

    logic          r_pre_vld;
    logic [N-1:0]  r_pre_data;
    logic [SW-1:0] r_pre_shift;
    logic          r_pre_fill;

    logic [SW-1:0] r_stg_vld;
    logic [N-1:0]  r_stg_data  [SW];
    logic [SW-1:0] r_stg_shift [SW];
    logic          r_stg_fill  [SW];

    logic [SW-1:0] w_stg_in_vld;
    logic [N-1:0]  w_stg_in_data  [SW];
    logic [SW-1:0] w_stg_in_shift [SW];
    logic          w_stg_in_fill  [SW];
    logic [N-1:0]  w_stg_out_data [SW];

    assign w_is_lsr = (arg_mode == 2'b10);
    assign w_is_div = (arg_mode == 2'b01);
    assign w_bias   = (ONE << arg_shift) - ONE;

    // Biasing a negative dividend by 2^s-1 turns the floor shift into truncation toward zero.
    assign w_pre_data = (w_is_div && arg[N-1]) ? (arg + w_bias) : arg;

    // The fill follows the sign of the (possibly biased) operand: a small negative dividend
    // such as -1 with s=3 biases to a non-negative value and must shift in zeros.
    assign w_pre_fill = w_is_lsr ? 1'b0 : w_pre_data[N-1];

    always_comb begin
        w_stg_in_vld[0]   = r_pre_vld;
        w_stg_in_data[0]  = r_pre_data;
        w_stg_in_shift[0] = r_pre_shift;
        w_stg_in_fill[0]  = r_pre_fill;
        for (int k = 1; k < SW; k++) begin
            w_stg_in_vld[k]   = r_stg_vld[k-1];
            w_stg_in_data[k]  = r_stg_data[k-1];
            w_stg_in_shift[k] = r_stg_shift[k-1];
            w_stg_in_fill[k]  = r_stg_fill[k-1];
        end
    end

    // Stage k shifts by 2^k when shift bit k is set; vacated MSBs take the fill bit.
    always_comb begin
        for (int k = 0; k < SW; k++) begin
            w_stg_out_data[k] = w_stg_in_data[k];
            if (w_stg_in_shift[k][k]) begin
                w_stg_out_data[k] = (w_stg_in_data[k] >> (1 << k))
                                  | ({N{w_stg_in_fill[k]}} & ~(ALL_ONES >> (1 << k)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_vld   <= 1'b0;
            r_pre_data  <= '0;
            r_pre_shift <= '0;
            r_pre_fill  <= 1'b0;
            r_stg_vld   <= '0;
            for (int k = 0; k < SW; k++) begin
                r_stg_data[k]  <= '0;
                r_stg_shift[k] <= '0;
                r_stg_fill[k]  <= 1'b0;
            end
        end else begin
            r_pre_vld <= arg_vld;
            if (arg_vld) begin
                r_pre_data  <= w_pre_data;
                r_pre_shift <= arg_shift;
                r_pre_fill  <= w_pre_fill;
            end
            // Valids advance every cycle; data only loads behind a valid so bubbles hold.
            for (int k = 0; k < SW; k++) begin
                r_stg_vld[k] <= w_stg_in_vld[k];
                if (w_stg_in_vld[k]) begin
                    r_stg_data[k]  <= w_stg_out_data[k];
                    r_stg_shift[k] <= w_stg_in_shift[k];
                    r_stg_fill[k]  <= w_stg_in_fill[k];
                end
            end
        end
    end

    assign res_vld = r_stg_vld[SW-1];
    assign res     = r_stg_data[SW-1];

endmodule

// File: tb/tb_signed_pow2_shift_divide_pipe.sv
// Self-checking bench for signed_pow2_shift_divide_pipe (N=8, latency 4).
module tb_signed_pow2_shift_divide_pipe;

    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst;
    logic          arg_vld;
    logic [N-1:0]  arg;
    logic [SW-1:0] arg_shift;
    logic [1:0]    arg_mode;
    logic          res_vld;
    logic [N-1:0]  res;

    logic [N-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    signed_pow2_shift_divide_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_vld   (arg_vld),
        .arg       (arg),
        .arg_shift (arg_shift),
        .arg_mode  (arg_mode),
        .res_vld   (res_vld),
        .res       (res)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] ref_model(input logic [N-1:0] a, input logic [SW-1:0] s,
                                               input logic [1:0] m);
        logic signed [N-1:0] sa;
        int ia;
        sa = a;
        ia = sa;
        case (m)
            2'b10:   return a >> s;
            2'b01:   begin ia = ia / (1 << s); return ia[N-1:0]; end
            default: return sa >>> s;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] a, input logic [SW-1:0] s, input logic [1:0] m,
                         input logic [N-1:0] e);
        arg       = a;
        arg_shift = s;
        arg_mode  = m;
        arg_vld   = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        arg_vld   = 1'b0;
        arg       = 8'($urandom_range(0, 255));
        arg_shift = 3'($urandom_range(0, 7));
        arg_mode  = 2'($urandom_range(0, 3));
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (res_vld === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: res_vld=1 res=%h with no transaction outstanding", res);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (res !== e) begin
                    errors++;
                    $display("FAIL sb_data: res=%h expected=%h", res, e);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        arg_vld   = 1'b1;
        arg       = 8'hA5;
        arg_shift = 3'd0;
        arg_mode  = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (res_vld !== 1'b0) begin
                errors++;
                $display("FAIL reset_vld: cycle %0d res_vld=%b expected=0", c, res_vld);
            end
            checks++;
            if (res !== 8'h00) begin
                errors++;
                $display("FAIL reset_res: cycle %0d res=%h expected=00", c, res);
            end
        end
    endtask

    task automatic test_modes();
        logic [N-1:0]  ta [18];
        logic [SW-1:0] ts [18];
        logic [1:0]    tm [18];
        logic [N-1:0]  te [18];
        ta = '{8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF,
               8'hFF, 8'h64, 8'h64, 8'h64, 8'h64, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        ts = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd3,
               3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
        tm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
               2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        te = '{8'hFC, 8'hFD, 8'h7C, 8'hFC, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'hFF,
               8'h00, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        for (int i = 0; i < 18; i++) begin
            drive(ta[i], ts[i], tm[i], te[i]);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c == 1) idle();
                checks++;
                if (res_vld !== (c == 4)) begin
                    errors++;
                    $display("FAIL mode_latency: vec %0d cycle %0d res_vld=%b expected=%b",
                             i, c, res_vld, (c == 4));
                end
            end
            checks++;
            if (res !== te[i]) begin
                errors++;
                $display("FAIL mode_result: vec %0d a=%h s=%0d m=%0d res=%h expected=%h",
                         i, ta[i], ts[i], tm[i], res, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]  ea [9];
        logic [N-1:0]  a;
        logic [SW-1:0] s;
        logic [1:0]    m;
        logic          ev;
        int idx;
        idx = 0;
        for (int t = 0; t < 16; t++) begin
            if (t >= 4) begin
                ev = (t <= 11) || (t == 14);
                checks++;
                if (res_vld !== ev) begin
                    errors++;
                    $display("FAIL stream_vld: t=%0d res_vld=%b expected=%b", t, res_vld, ev);
                end
                if (t == 12 || t == 13) begin
                    checks++;
                    if (res !== ea[7]) begin
                        errors++;
                        $display("FAIL stream_hold: t=%0d res=%h expected=%h", t, res, ea[7]);
                    end
                end
                if (t == 14) begin
                    checks++;
                    if (res !== ea[8]) begin
                        errors++;
                        $display("FAIL stream_ninth: res=%h expected=%h", res, ea[8]);
                    end
                end
            end
            if (t < 8 || t == 10) begin
                a = 8'($urandom_range(0, 255));
                s = 3'($urandom_range(0, 7));
                m = 2'($urandom_range(0, 3));
                ea[idx] = ref_model(a, s, m);
                drive(a, s, m, ea[idx]);
                idx++;
            end else begin
                idle();
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_flight();
        for (int t = 0; t < 3; t++) begin
            drive(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'h00);
            @(negedge clk);
        end
        idle();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (res_vld !== 1'b0) begin
                errors++;
                $display("FAIL midrst_vld: cycle %0d res_vld=%b expected=0", c, res_vld);
            end
            checks++;
            if (res !== 8'h00) begin
                errors++;
                $display("FAIL midrst_res: cycle %0d res=%h expected=00", c, res);
            end
            @(negedge clk);
        end
        // reset together with a valid input: that input must vanish
        rst       = 1'b1;
        arg_vld   = 1'b1;
        arg       = 8'h3C;
        arg_shift = 3'd2;
        arg_mode  = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        drive(8'hB3, 3'd2, 2'b01, 8'hED);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) idle();
            checks++;
            if (res_vld !== (c == 4)) begin
                errors++;
                $display("FAIL postrst_latency: cycle %0d res_vld=%b expected=%b", c, res_vld, (c == 4));
            end
        end
        checks++;
        if (res !== 8'hED) begin
            errors++;
            $display("FAIL postrst_result: res=%h expected=ed", res);
        end
    endtask

    task automatic test_random_sweep();
        logic [N-1:0]  a;
        logic [SW-1:0] s;
        logic [1:0]    m;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 99) < 85) begin
                a = 8'($urandom_range(0, 255));
                s = 3'($urandom_range(0, 7));
                m = 2'($urandom_range(0, 3));
                drive(a, s, m, ref_model(a, s, m));
            end else begin
                idle();
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic drain();
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_reset_mid_flight();
        test_random_sweep();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
